sram_ctrl_ws: RTL and testbench

- Parametrised controller for an external asynchronous SRAM with byte lanes, placed between a fabric-side command port and the SRAM pins.
- Read and write strobe lengths are configurable through wait-state parameters, and byte-lane enables come from the command.
- The command port is a valid/ready handshake; read data returns as a one-cycle valid pulse.
- Every SRAM pin is driven from a register, and the shared data bus always has at least one undriven cycle between a read and a following write.

---
 rtl/sram_ctrl_ws.sv | 166 ++++++++++++++++
 tb/tb_sram_ctrl_ws.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_ctrl_ws.sv
// rtl/sram_ctrl_ws.sv - asynchronous SRAM controller with byte lanes and wait states
//
// Purpose: bridges a valid/ready command port to an external asynchronous SRAM.
// Write strobe width is WR_WAIT cycles followed by one data-hold cycle; read
// strobe width is RD_WAIT cycles with data captured on the last edge of the
// strobe. Every SRAM pin, including the data-bus output enable, is a register
// loaded from the next-state decode.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_rw                1 = read, 0 = write
//   cmd_addr/wdata/be     word address, write data, active-high byte enables
//   rd_valid/rd_data      one-cycle read completion pulse, held read data
//   ad, ce_n, we_n, oe_n  SRAM address and active-low strobes
//   be_n                  SRAM active-low byte-lane selects
//   dio                   SRAM bidirectional data bus

module sram_ctrl_ws #(
   parameter int ADDR_W  = 18,
   parameter int DATA_W  = 16,
   parameter int RD_WAIT = 2,
   parameter int WR_WAIT = 2
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                cmd_valid,
   output logic                cmd_ready,
   input  logic                cmd_rw,
   input  logic [ADDR_W-1:0]   cmd_addr,
   input  logic [DATA_W-1:0]   cmd_wdata,
   input  logic [DATA_W/8-1:0] cmd_be,
   output logic                rd_valid,
   output logic [DATA_W-1:0]   rd_data,
   output logic [ADDR_W-1:0]   ad,
   output logic                ce_n,
   output logic                we_n,
   output logic                oe_n,
   output logic [DATA_W/8-1:0] be_n,
   inout  wire  [DATA_W-1:0]   dio
);

   localparam int BE_W     = DATA_W / 8;
   localparam int MAX_WAIT = (RD_WAIT > WR_WAIT) ? RD_WAIT : WR_WAIT;
   localparam int CNT_W    = $clog2(MAX_WAIT + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WR      = 2'd1,
      WR_HOLD = 2'd2,
      RD      = 2'd3
   } state_t;

   state_t              state_q,    state_d;
   logic [CNT_W-1:0]    cnt_q,      cnt_d;
   logic [ADDR_W-1:0]   ad_q,       ad_d;
   logic [DATA_W-1:0]   wdata_q,    wdata_d;
   logic [BE_W-1:0]     be_n_q,     be_n_d;
   logic                ce_n_q,     ce_n_d;
   logic                we_n_q,     we_n_d;
   logic                oe_n_q,     oe_n_d;
   logic                dio_oe_q,   dio_oe_d;
   logic                rd_valid_q, rd_valid_d;
   logic [DATA_W-1:0]   rd_data_q,  rd_data_d;

   // Next-state and pin decode. Pins are derived from state_d so that each
   // strobe register changes on the same edge the state is entered.
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      ad_d       = ad_q;
      wdata_d    = wdata_q;
      be_n_d     = be_n_q;
      rd_valid_d = 1'b0;
      rd_data_d  = rd_data_q;

      case (state_q)
         IDLE: begin
            if (cmd_valid) begin
               ad_d    = cmd_addr;
               wdata_d = cmd_wdata;
               if (cmd_rw) begin
                  state_d = RD;
                  cnt_d   = CNT_W'(RD_WAIT - 1);
                  be_n_d  = '0;
               end else begin
                  state_d = WR;
                  cnt_d   = CNT_W'(WR_WAIT - 1);
                  be_n_d  = ~cmd_be;
               end
            end
         end
         WR: begin
            if (cnt_q == '0) begin
               state_d = WR_HOLD;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         WR_HOLD: begin
            state_d = IDLE;
         end
         RD: begin
            if (cnt_q == '0) begin
               // last edge of the oe_n strobe: the bus has settled for RD_WAIT cycles
               rd_data_d  = dio;
               rd_valid_d = 1'b1;
               state_d    = IDLE;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      ce_n_d   = (state_d == IDLE);
      we_n_d   = (state_d != WR);
      oe_n_d   = (state_d != RD);
      // the bus stays driven through WR_HOLD to give data hold after we_n rises
      dio_oe_d = (state_d == WR) || (state_d == WR_HOLD);
      if (state_d == IDLE) begin
         be_n_d = '1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         ad_q       <= '0;
         wdata_q    <= '0;
         be_n_q     <= '1;
         ce_n_q     <= 1'b1;
         we_n_q     <= 1'b1;
         oe_n_q     <= 1'b1;
         dio_oe_q   <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         ad_q       <= ad_d;
         wdata_q    <= wdata_d;
         be_n_q     <= be_n_d;
         ce_n_q     <= ce_n_d;
         we_n_q     <= we_n_d;
         oe_n_q     <= oe_n_d;
         dio_oe_q   <= dio_oe_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   assign cmd_ready = (state_q == IDLE);
   assign rd_valid  = rd_valid_q;
   assign rd_data   = rd_data_q;
   assign ad        = ad_q;
   assign ce_n      = ce_n_q;
   assign we_n      = we_n_q;
   assign oe_n      = oe_n_q;
   assign be_n      = be_n_q;
   assign dio       = dio_oe_q ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_ctrl_ws.sv
// tb/tb_sram_ctrl_ws.sv - self-checking bench for sram_ctrl_ws at wait states 2, 1 and 4

module tb_sram_ctrl_ws;

   localparam int NI = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                   reset_n = 1'b0;
   logic [NI-1:0]          cmd_valid;
   logic [NI-1:0]          cmd_rw;
   logic [NI-1:0][17:0]    cmd_addr;
   logic [NI-1:0][15:0]    cmd_wdata;
   logic [NI-1:0][1:0]     cmd_be;
   wire  [NI-1:0]          cmd_ready;
   wire  [NI-1:0]          rd_valid;
   wire  [NI-1:0]          ce_n;
   wire  [NI-1:0]          we_n;
   wire  [NI-1:0]          oe_n;
   wire  [NI-1:0][15:0]    rd_data;
   wire  [NI-1:0][15:0]    dio_mon;
   wire  [NI-1:0][17:0]    ad;
   wire  [NI-1:0][1:0]     be_n;

   int n_chk  = 0;
   int n_pass = 0;

   // reference contents of instance 0's SRAM, updated per accepted write
   logic [15:0] shadow [1024];

   for (genvar g = 0; g < NI; g++) begin : inst
      localparam int W = (g == 0) ? 2 : (g == 1) ? 1 : 4;
      wire  [15:0] dio;
      logic [15:0] mem [1024] = '{default: 16'h0000};

      sram_ctrl_ws #(
         .ADDR_W (18),
         .DATA_W (16),
         .RD_WAIT(W),
         .WR_WAIT(W)
      ) dut (
         .clk      (clk),
         .reset_n  (reset_n),
         .cmd_valid(cmd_valid[g]),
         .cmd_ready(cmd_ready[g]),
         .cmd_rw   (cmd_rw[g]),
         .cmd_addr (cmd_addr[g]),
         .cmd_wdata(cmd_wdata[g]),
         .cmd_be   (cmd_be[g]),
         .rd_valid (rd_valid[g]),
         .rd_data  (rd_data[g]),
         .ad       (ad[g]),
         .ce_n     (ce_n[g]),
         .we_n     (we_n[g]),
         .oe_n     (oe_n[g]),
         .be_n     (be_n[g]),
         .dio      (dio)
      );

      // asynchronous SRAM: write latched on the rising edge of we_n
      always @(posedge we_n[g]) begin
         if (!ce_n[g] && reset_n) begin
            for (int b = 0; b < 2; b++) begin
               if (!be_n[g][b]) mem[ad[g][9:0]][b*8 +: 8] <= dio[b*8 +: 8];
            end
         end
      end

      assign dio        = (!ce_n[g] && !oe_n[g]) ? mem[ad[g][9:0]] : 16'hzzzz;
      assign dio_mon[g] = dio;
   end

   function automatic int wait_of(input int i);
      return (i == 0) ? 2 : (i == 1) ? 1 : 4;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic model_write(input logic [17:0] a, input logic [15:0] d, input logic [1:0] be);
      for (int b = 0; b < 2; b++) begin
         if (be[b]) shadow[a[9:0]][b*8 +: 8] = d[b*8 +: 8];
      end
   endtask

   // Issue one command on instance i at a negedge and follow it to completion,
   // checking strobe widths, hold cycle, handshake and read data. Returns at
   // the negedge of the cycle where cmd_ready is high again.
   task automatic do_cmd(input int i, input logic rw, input logic [17:0] a,
                         input logic [15:0] d, input logic [1:0] be,
                         input logic [15:0] exp_rd, input string tag);
      int         w, n, rdy_k, rv_k, low_n, last_low;
      logic [1:0] be_n_exp;
      w        = wait_of(i);
      be_n_exp = rw ? 2'b00 : ~be;
      n        = 0;
      while (cmd_ready[i] !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, ".ready"}, cmd_ready[i], 1);
      chk({tag, ".idle_strobes"}, {ce_n[i], we_n[i], oe_n[i], be_n[i]}, 5'b11111);
      cmd_valid[i] = 1'b1;
      cmd_rw[i]    = rw;
      cmd_addr[i]  = a;
      cmd_wdata[i] = d;
      cmd_be[i]    = be;
      rdy_k = 0; rv_k = 0; low_n = 0; last_low = 0;
      for (int k = 1; k <= 20 && rdy_k == 0; k++) begin
         @(negedge clk);
         // scrambled inputs outside IDLE must have no effect
         cmd_valid[i] = 1'b0;
         cmd_rw[i]    = 1'($urandom);
         cmd_addr[i]  = 18'($urandom);
         cmd_wdata[i] = 16'($urandom);
         cmd_be[i]    = 2'($urandom);
         if (rw ? !oe_n[i] : !we_n[i]) begin
            low_n++;
            last_low = k;
         end
         if (rd_valid[i] && rv_k == 0) rv_k = k;
         if (cmd_ready[i]) rdy_k = k;
         if (k == 1) begin
            chk({tag, ".ad"}, ad[i], a);
            chk({tag, ".be_n"}, be_n[i], be_n_exp);
            chk({tag, ".ce_n"}, ce_n[i], 0);
            chk({tag, ".other_strobe"}, rw ? we_n[i] : oe_n[i], 1);
         end
         if (!rw && k == w + 1) begin
            chk({tag, ".hold_we_n"}, we_n[i], 1);
            chk({tag, ".hold_ce_n"}, ce_n[i], 0);
            chk({tag, ".hold_dio"}, dio_mon[i], d);
            chk({tag, ".hold_be_n"}, be_n[i], be_n_exp);
            chk({tag, ".hold_ad"}, ad[i], a);
         end
      end
      chk({tag, ".strobe_width"}, low_n, w);
      chk({tag, ".strobe_end"}, last_low, w);
      if (rw) begin
         chk({tag, ".ready_cycle"}, rdy_k, w + 1);
         chk({tag, ".rd_valid_cycle"}, rv_k, w + 1);
         chk({tag, ".rd_data"}, rd_data[i], exp_rd);
      end else begin
         chk({tag, ".ready_cycle"}, rdy_k, w + 2);
         chk({tag, ".no_rd_valid"}, rv_k, 0);
      end
   endtask

   typedef struct {
      logic        rw;
      logic [17:0] addr;
      logic [15:0] wdata;
      logic [1:0]  be;
      logic [15:0] exp_rd;
   } vec_t;

   vec_t tbl [8];

   initial begin : main
      logic       rv_seen;
      logic       r_rw;
      logic [17:0] r_a;
      logic [15:0] r_d, r_exp;
      logic [1:0] r_be;

      for (int j = 0; j < 1024; j++) shadow[j] = 16'h0000;
      cmd_valid = '1;
      cmd_rw    = '0;
      cmd_addr  = '0;
      cmd_wdata = '0;
      cmd_be    = '1;

      // reset held for 3 cycles with a command presented
      repeat (3) @(negedge clk);
      chk("rst.strobes", {ce_n[0], we_n[0], oe_n[0]}, 3'b111);
      chk("rst.be_n", be_n[0], 2'b11);
      chk("rst.rd_valid", rd_valid[0], 0);
      chk("rst.ad", ad[0], 0);
      chk("rst.rd_data", rd_data[0], 0);
      cmd_valid = '0;
      reset_n   = 1'b1;
      @(negedge clk);
      chk("rst.ready_after", cmd_ready[0], 1);
      chk("rst.no_accept", ce_n[0], 1);

      // directed vectors; consecutive entries run back to back, so the write
      // after a read is accepted in the rd_valid cycle
      tbl[0] = '{1'b0, 18'h000A5, 16'hBEEF, 2'b11, 16'h0000};
      tbl[1] = '{1'b1, 18'h000A5, 16'h0000, 2'b00, 16'hBEEF};
      tbl[2] = '{1'b0, 18'h00005, 16'h1234, 2'b11, 16'h0000};
      tbl[3] = '{1'b0, 18'h00005, 16'hABCD, 2'b01, 16'h0000};
      tbl[4] = '{1'b1, 18'h00005, 16'h0000, 2'b00, 16'h12CD};
      tbl[5] = '{1'b0, 18'h00005, 16'h5555, 2'b00, 16'h0000};
      tbl[6] = '{1'b1, 18'h00005, 16'h0000, 2'b00, 16'h12CD};
      tbl[7] = '{1'b1, 18'h000A5, 16'h0000, 2'b00, 16'hBEEF};
      for (int v = 0; v < 8; v++) begin
         do_cmd(0, tbl[v].rw, tbl[v].addr, tbl[v].wdata, tbl[v].be, tbl[v].exp_rd,
                $sformatf("vec%0d", v));
         if (!tbl[v].rw) model_write(tbl[v].addr, tbl[v].wdata, tbl[v].be);
      end

      // reset asserted during the second oe_n-low cycle of a read
      cmd_valid[0] = 1'b1;
      cmd_rw[0]    = 1'b1;
      cmd_addr[0]  = 18'h00005;
      @(negedge clk);
      cmd_valid[0] = 1'b0;
      @(negedge clk);
      chk("midrd.oe_low", oe_n[0], 0);
      #2 reset_n = 1'b0;
      #1;
      chk("midrd.oe_n", oe_n[0], 1);
      chk("midrd.ce_n", ce_n[0], 1);
      rv_seen = 1'b0;
      repeat (3) begin
         @(negedge clk);
         rv_seen = rv_seen | rd_valid[0];
      end
      reset_n = 1'b1;
      repeat (4) begin
         @(negedge clk);
         rv_seen = rv_seen | rd_valid[0];
      end
      chk("midrd.no_rd_valid", rv_seen, 0);
      chk("midrd.ready", cmd_ready[0], 1);
      do_cmd(0, 1'b1, 18'h00005, 16'h0000, 2'b00, 16'h12CD, "midrd.after");

      // wait-state sweep on the 1-cycle and 4-cycle instances
      for (int i = 1; i < NI; i++) begin
         do_cmd(i, 1'b0, 18'h000A5, 16'hBEEF, 2'b11, 16'h0000, $sformatf("sw%0d.wr", i));
         do_cmd(i, 1'b1, 18'h000A5, 16'h0000, 2'b00, 16'hBEEF, $sformatf("sw%0d.rd", i));
      end

      // randomized traffic on a small address window against the shadow model
      for (int t = 0; t < 80; t++) begin
         r_rw  = 1'($urandom);
         r_a   = 18'($urandom_range(0, 15));
         r_d   = 16'($urandom);
         r_be  = 2'($urandom);
         r_exp = shadow[r_a[9:0]];
         do_cmd(0, r_rw, r_a, r_d, r_be, r_exp, $sformatf("rnd%0d", t));
         if (!r_rw) model_write(r_a, r_d, r_be);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule
